vip_frame_source: RTL and testbench



---
 rtl/vip_frame_source.sv | 133 +++++++++++++
 tb/tb_vip_frame_source.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vip_frame_source.sv
// Camera-style frame source: scans a stored RGB888 frame out of a synchronous RAM
// with vsync/href/clken timing, one pixel every two clocks.
module vip_frame_source #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int H_SYNC    = 5,
    parameter int H_BACK    = 5,
    parameter int H_FRONT   = 5,
    parameter int V_SYNC    = 1,
    parameter int V_BACK    = 0,
    parameter int V_FRONT   = 1,
    parameter int ADDR_W    = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [23:0]       rd_data,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic [23:0]       post_img_data,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BACK + IMG_HDISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + IMG_VDISP + V_FRONT;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT0 = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_ACT1 = HW'(H_SYNC + H_BACK + IMG_HDISP);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT0 = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_ACT1 = VW'(V_SYNC + V_BACK + IMG_VDISP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic            tick;
    logic [HW-1:0]   hcnt;
    logic [VW-1:0]   vcnt;
    logic            run, active, wrap;
    logic            vs_d1, hr_d1, ck_d1;

    assign run    = (state_q == RUN);
    assign active = run && (vcnt >= V_ACT0) && (vcnt < V_ACT1) &&
                    (hcnt >= H_ACT0) && (hcnt < H_ACT1);
    assign wrap   = run && tick && (hcnt == H_LAST) && (vcnt == V_LAST);
    assign busy   = run;
    assign rd_en  = active && tick;

    always_comb begin
        rd_addr = '0;
        if (active)
            rd_addr = ADDR_W'(vcnt - V_ACT0) * ADDR_W'(IMG_HDISP) + ADDR_W'(hcnt - H_ACT0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (wrap && !cont) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // On a stopping wrap the counters fall back to zero by themselves since tick=1 there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= 1'b0;
            hcnt <= '0;
            vcnt <= '0;
        end else if (!run) begin
            tick <= 1'b0;
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            tick <= ~tick;
            if (tick) begin
                if (hcnt == H_LAST) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= wrap;
            if (wrap) frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Two-stage timing pipeline; data lands in stage two because RAM has one cycle latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d1            <= 1'b0;
            hr_d1            <= 1'b0;
            ck_d1            <= 1'b0;
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_data    <= '0;
        end else begin
            vs_d1            <= run && (vcnt >= V_SYNC_END);
            hr_d1            <= active;
            ck_d1            <= active && tick;
            post_frame_vsync <= vs_d1;
            post_frame_href  <= hr_d1;
            post_frame_clken <= ck_d1;
            if (ck_d1) post_img_data <= rd_data;
        end
    end

endmodule

// File: tb/tb_vip_frame_source.sv
// Scoreboard bench for vip_frame_source on a 4x2 frame (H_TOTAL=19, V_TOTAL=4, 152 clk/frame).
module tb_vip_frame_source;

    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          cont = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [23:0]   rd_data = '0;
    logic          vsync, href, clken;
    logic [23:0]   img_data;
    logic          busy, frame_done;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    vip_frame_source #(.IMG_HDISP(4), .IMG_VDISP(2), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .post_frame_vsync(vsync), .post_frame_href(href), .post_frame_clken(clken),
        .post_img_data(img_data), .busy(busy), .frame_done(frame_done),
        .frame_cnt(frame_cnt)
    );

    function automatic logic [23:0] pix(input logic [AW-1:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {8'h00, b, b + 8'h10};
    endfunction

    always @(posedge clk) if (rd_en) rd_data <= pix(rd_addr);

    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // scoreboard state shared with the monitor
    logic [AW-1:0] exp_q[$];
    int fd_q[$];
    int vs_q[$];
    int cyc = 0, clk_cnt = 0, rd_cnt = 0, busy_rise = -1, run_len = 0;
    bit in_run = 0;
    logic          href_h1 = 0, clken_h1 = 0, href_h2 = 0, clken_h2 = 0, busy_h1 = 0, vs_h1 = 0;
    logic          rd_en_h1 = 0, rd_en_h2 = 0;
    logic [AW-1:0] rd_addr_h1 = '0, rd_addr_h2 = '0;
    logic [AW-1:0] k;

    always @(negedge clk) begin
        cyc++;
        if (clken) begin
            clk_cnt++;
            if (exp_q.size() == 0) begin
                check("pix_unexpected", 1, 0);
            end else begin
                k = exp_q.pop_front();
                check("pix_data", img_data, pix(k));
                check("rd_2clk_before", {rd_en_h2, rd_addr_h2}, {1'b1, k});
                check("href_lead", {href_h1, clken_h1, href_h2 & ~clken_h2}, 3'b100);
            end
        end
        if (rd_en) rd_cnt++;
        if (frame_done) fd_q.push_back(cyc);
        if (busy && !busy_h1) busy_rise = cyc;
        if (!busy) in_run = 0;
        else if (!vsync && vs_h1) begin in_run = 1; run_len = 1; end
        else if (!vsync && in_run) run_len++;
        else if (vsync && in_run) begin vs_q.push_back(run_len); in_run = 0; end
        href_h2 = href_h1;   clken_h2 = clken_h1;
        href_h1 = href;      clken_h1 = clken;
        rd_en_h2 = rd_en_h1; rd_addr_h2 = rd_addr_h1;
        rd_en_h1 = rd_en;    rd_addr_h1 = rd_addr;
        busy_h1 = busy;      vs_h1 = vsync;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic push_frame();
        for (int i = 0; i < 8; i++) exp_q.push_back(AW'(i));
    endtask

    task automatic wait_fd(input int n, input int budget);
        int b;
        b = 0;
        while (fd_q.size() < n && b < budget) begin step(); b++; end
        if (fd_q.size() < n) check("timeout_frame_done", fd_q.size(), n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
    endtask

    int c0, r0, bad, b;

    initial begin
        // reset values
        repeat (3) step();
        check("rst_vsync", vsync, 0);
        check("rst_href", href, 0);
        check("rst_clken", clken, 0);
        check("rst_img_data", img_data, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        rst = 1'b0;
        step();

        // single frame, cont=0
        push_frame();
        c0 = clk_cnt; r0 = rd_cnt; fd_q.delete();
        pulse_start();
        wait_fd(1, 400);
        if (fd_q.size() >= 1) check("done_latency", fd_q[0] - busy_rise, 152);
        repeat (60) step();
        check("single_clken_count", clk_cnt - c0, 8);
        check("single_sb_empty", exp_q.size(), 0);
        check("single_frame_cnt", frame_cnt, 1);
        check("single_busy_low", busy, 0);
        check("single_rd_count", rd_cnt - r0, 8);

        // continuous frames, stray start while busy, cont cleared in frame 3
        do_reset();
        fd_q.delete(); vs_q.delete();
        repeat (3) push_frame();
        cont = 1'b1;
        pulse_start();
        repeat (50) step();
        pulse_start();
        wait_fd(2, 500);
        repeat (20) step();
        cont = 1'b0;
        wait_fd(3, 300);
        repeat (200) step();
        check("cont_done_count", fd_q.size(), 3);
        if (fd_q.size() >= 3) begin
            check("cont_spacing_1_2", fd_q[1] - fd_q[0], 152);
            check("cont_spacing_2_3", fd_q[2] - fd_q[1], 152);
        end
        check("cont_frame_cnt", frame_cnt, 3);
        check("cont_busy_low", busy, 0);
        check("cont_sb_empty", exp_q.size(), 0);
        check("vsync_low_runs", vs_q.size(), 2);
        foreach (vs_q[i]) check("vsync_low_len", vs_q[i], 38);

        // reset in the middle of an active line
        push_frame();
        pulse_start();
        b = 0;
        while (!href && b < 200) begin step(); b++; end
        if (!href) check("timeout_href", href, 1);
        rst = 1'b1;
        exp_q.delete();
        step();
        check("abort_ctrl_zero", {vsync, href, clken, rd_en, busy, frame_done, frame_cnt}, 0);
        check("abort_data_zero", {img_data, rd_addr}, 0);
        repeat (2) step();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if ({vsync, href, clken, img_data, rd_en, rd_addr, busy, frame_done, frame_cnt} != 0) bad++;
        end
        check("idle_after_abort", bad, 0);
        push_frame();
        c0 = clk_cnt; fd_q.delete();
        pulse_start();
        wait_fd(1, 400);
        repeat (5) step();
        check("restart_clken_count", clk_cnt - c0, 8);
        check("restart_sb_empty", exp_q.size(), 0);
        check("restart_frame_cnt", frame_cnt, 1);

        // frame counter rollover
        force dut.frame_cnt = 16'hFFFF;
        step();
        release dut.frame_cnt;
        push_frame();
        fd_q.delete();
        pulse_start();
        wait_fd(1, 400);
        step();
        check("rollover_frame_cnt", frame_cnt, 0);
        check("rollover_done_pulse", fd_q.size(), 1);
        check("rollover_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
